disp_scheduler: RTL
===================

DISP_SCHEDULER -- requirements
Module: disp_scheduler

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 25000000, clock cycles each grant holds the display (legal range 1..2^26-1).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  4  request from requester i on bit i; requester holds it high until its ack.
REQ-005 SHALL have port req_value  input  24  signed 6-bit two's-complement value of requester i on bits [6i+5:6i].
REQ-006 SHALL have port ack  output  4  one-hot, one-cycle pulse marking the requester whose value was captured.
REQ-007 SHALL have port disp_value  output  6  captured signed value driven to the two-digit display datapath.
REQ-008 SHALL have port disp_neg  output  1  sign of disp_value (equals disp_value[5]).
REQ-009 SHALL have port disp_src  output  2  index of requester owning disp_value.
REQ-010 SHALL have port disp_valid  output  1  high while a grant is being displayed.

Function
REQ-011 SHALL implement FSM states IDLE and HOLD, plus a 26-bit dwell down-counter and 2-bit register last_src.
REQ-012 SHALL, in IDLE with req != 0, grant on that rising edge; IDLE with req == 0 SHALL stay IDLE.
REQ-013 SHALL select the grant round-robin: first set req bit searching from (last_src+1) mod 4 upward, wrapping.
REQ-014 SHALL, on a grant edge, register disp_value = selected slice, disp_src = last_src = winner index, counter = DWELL_CYCLES-1, disp_valid = 1, state = HOLD.
REQ-015 SHALL assert ack[winner] for exactly the one cycle following the grant edge; all other cycles ack = 0.
REQ-016 SHALL, in HOLD with counter != 0, decrement the counter once per cycle and ignore req (no ack).
REQ-017 SHALL, in HOLD with counter == 0 and req != 0, grant per REQ-013/REQ-014 on that edge (back-to-back, no idle cycle).
REQ-018 SHALL, in HOLD with counter == 0 and req == 0, enter IDLE, drop disp_valid, and retain disp_value/disp_src/disp_neg unchanged.
REQ-019 SHALL re-grant the same requester when it is the only one requesting at a grant point.
REQ-020 SHALL treat a req deasserted before its grant as never requested; no value captured.
REQ-021 SHALL hold each grant exactly DWELL_CYCLES cycles of disp_valid before the next grant edge; DWELL_CYCLES = 1 yields one grant per cycle when requests persist.
REQ-022 SHALL pass all 64 codes including 6'b100000 (-32) unmodified; no saturation or conversion in this block.

Reset
REQ-023 SHALL, while rst_n = 0, force state IDLE, counter 0, last_src 3, ack 0, disp_value 0, disp_neg 0, disp_src 0, disp_valid 0, independent of clk.
REQ-024 SHALL, on reset asserted mid-HOLD, abandon the grant; after release requester 0 holds first priority.

Configuration
REQ-025 SHALL support macro DISP_SCHED_PREEMPT_EN.
REQ-026 SHALL, with DISP_SCHED_PREEMPT_EN defined, grant requester 0 on any HOLD edge where req[0] = 1 and disp_src != 0, regardless of counter (ack, capture, reload per REQ-014/015).
REQ-027 SHALL, without DISP_SCHED_PREEMPT_EN, never preempt; requester 0 waits for counter expiry like all others.

Verification (DWELL_CYCLES = 4)
REQ-028 SHALL cover: reset release, req=4'b0001, value0=6'd7 -> ack=0001 one cycle, disp_value=7, disp_neg=0, disp_src=0, disp_valid high 4 cycles, then IDLE with value retained.
REQ-029 SHALL cover: req=4'b1111 held, values 1,2,3,4 -> grants in order 0,1,2,3,0, each 4 cycles apart, no idle gap.
REQ-030 SHALL cover: value2=6'b100000 alone -> disp_value=6'b100000, disp_neg=1, disp_src=2.
REQ-031 SHALL cover: rst_n low two cycles into HOLD -> all outputs zero immediately; next req=4'b1001 grants requester 0.
REQ-032 SHALL cover: src 1 in HOLD, req[0] raised at dwell cycle 1 -> with DISP_SCHED_PREEMPT_EN grant 0 on next edge; without, grant 0 only after counter reaches 0.

Source files
------------

// File: rtl/disp_scheduler.sv
// Round-robin scheduler that lends a shared two-digit display to four requesters for a fixed dwell.
// Optional build macro DISP_SCHED_PREEMPT_EN lets requester 0 cut short any other requester's dwell.
module disp_scheduler #(
   parameter int unsigned DWELL_CYCLES = 25000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   input  logic [23:0] req_value,
   output logic [3:0]  ack,
   output logic [5:0]  disp_value,
   output logic        disp_neg,
   output logic [1:0]  disp_src,
   output logic        disp_valid
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam logic [25:0] RELOAD_C = 26'(DWELL_CYCLES - 32'd1);

   state_t      state_q, state_d;
   logic [25:0] cnt_q, cnt_d;
   logic [1:0]  last_src_q, last_src_d;
   logic [3:0]  ack_q, ack_d;
   logic [5:0]  disp_value_q, disp_value_d;
   logic        disp_neg_q, disp_neg_d;
   logic [1:0]  disp_src_q, disp_src_d;
   logic        disp_valid_q, disp_valid_d;

   logic        req_any_s;
   logic        base_grant_s;
   logic        preempt_s;
   logic        grant_s;
   logic [1:0]  rr_win_s;
   logic [1:0]  win_s;
   logic [5:0]  win_value_s;

   // First set request bit after the previous owner, wrapping back to the previous owner last.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
      logic [1:0] idx;
      logic [1:0] win;
      logic       found;
      win   = last;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = last + 2'(k);
         if (!found && r[idx]) begin
            win   = idx;
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return win;
   endfunction

   assign req_any_s = |req;
   assign rr_win_s  = rr_pick(req, last_src_q);

`ifdef DISP_SCHED_PREEMPT_EN
   assign preempt_s = (state_q == ST_HOLD) && req[0] && (disp_src_q != 2'd0);
`else
   assign preempt_s = 1'b0;
`endif

   // Grant points: any request while idle, or any request once the dwell has expired.
   always_comb begin
      base_grant_s = 1'b0;
      case (state_q)
         ST_IDLE: base_grant_s = req_any_s;
         ST_HOLD: begin
            if (cnt_q == 26'd0) begin
               base_grant_s = req_any_s;
            end else begin
               base_grant_s = 1'b0;
            end
         end
         default: base_grant_s = 1'b0;
      endcase
   end

   assign grant_s     = base_grant_s | preempt_s;
   assign win_s       = preempt_s ? 2'd0 : rr_win_s;
   assign win_value_s = req_value[6*win_s +: 6];

   // Next-state, capture and dwell countdown.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_src_d   = last_src_q;
      ack_d        = 4'b0000;
      disp_value_d = disp_value_q;
      disp_neg_d   = disp_neg_q;
      disp_src_d   = disp_src_q;
      disp_valid_d = disp_valid_q;
      if (grant_s) begin
         state_d      = ST_HOLD;
         cnt_d        = RELOAD_C;
         last_src_d   = win_s;
         ack_d        = 4'b0001 << win_s;
         disp_value_d = win_value_s;
         disp_neg_d   = win_value_s[5];
         disp_src_d   = win_s;
         disp_valid_d = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: disp_valid_d = 1'b0;
            ST_HOLD: begin
               // Expiry without requests keeps the last value on the display, just marked stale.
               if (cnt_q != 26'd0) begin
                  cnt_d = cnt_q - 26'd1;
               end else begin
                  state_d      = ST_IDLE;
                  disp_valid_d = 1'b0;
               end
            end
            default: begin
               state_d      = ST_IDLE;
               disp_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State and output registers; last_src resets to 3 so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 26'd0;
         last_src_q   <= 2'd3;
         ack_q        <= 4'b0000;
         disp_value_q <= 6'd0;
         disp_neg_q   <= 1'b0;
         disp_src_q   <= 2'd0;
         disp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_src_q   <= last_src_d;
         ack_q        <= ack_d;
         disp_value_q <= disp_value_d;
         disp_neg_q   <= disp_neg_d;
         disp_src_q   <= disp_src_d;
         disp_valid_q <= disp_valid_d;
      end
   end

   assign ack        = ack_q;
   assign disp_value = disp_value_q;
   assign disp_neg   = disp_neg_q;
   assign disp_src   = disp_src_q;
   assign disp_valid = disp_valid_q;

endmodule
